// File: rtl/pipe_skid_latch.sv
// rtl/pipe_skid_latch.sv - two-entry skid pipeline latch with step, flush, halt and transfer count
module pipe_skid_latch #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_step,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CTRL_WIDTH-1:0] i_ctrl,
    input  logic                  i_halt,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CTRL_WIDTH-1:0] o_ctrl,
    output logic                  o_halt,
    output logic                  o_halted,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic [1:0]            o_occupancy
);

    localparam int EW = 1 + CTRL_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [EW-1:0]          main_q, main_d;
    logic [EW-1:0]          skid_q, skid_d;
    logic                   halted_q, halted_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    logic [EW-1:0]          in_entry;
    logic                   in_xfer;
    logic                   out_xfer;

    assign in_entry = {i_halt, i_ctrl, i_data};

    // Handshakes are built only from registered state and step/ready/halted,
    // so no output has a combinational path from the upstream payload or valid.
    assign o_ready  = i_step & ~halted_q & (state_q != TWO);
    assign o_valid  = (state_q != EMPTY);
    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready & i_step & ~halted_q;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        halted_d = halted_q;
        count_d  = count_q;
        if (i_flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            if (out_xfer) begin
                count_d = count_q + CNT_WIDTH'(1);
                if (main_q[EW-1]) begin
                    halted_d = 1'b1;
                end
            end
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_entry;
                    end else if (in_xfer) begin
                        skid_d  = in_entry;
                        state_d = TWO;
                    end else if (out_xfer) begin
                        main_d  = '0;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign o_data      = o_valid ? main_q[DATA_WIDTH-1:0] : '0;
    assign o_ctrl      = o_valid ? main_q[DATA_WIDTH +: CTRL_WIDTH] : '0;
    assign o_halt      = o_valid & main_q[EW-1];
    assign o_halted    = halted_q;
    assign o_count     = count_q;
    assign o_occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb/tb_pipe_skid_latch.sv - randomized and directed bench for pipe_skid_latch against a queue model
module tb_pipe_skid_latch;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NW = 4;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_step;
    logic          i_flush;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [CW-1:0] i_ctrl;
    logic          i_halt;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_ctrl;
    logic          o_halt;
    logic          o_halted;
    logic [NW-1:0] o_count;
    logic [1:0]    o_occupancy;

    pipe_skid_latch #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl),
        .i_halt(i_halt), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_ctrl(o_ctrl), .o_halt(o_halt), .o_halted(o_halted), .o_count(o_count),
        .o_occupancy(o_occupancy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic          halt;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mq[$];
    logic          m_halted;
    logic [NW-1:0] m_count;
    int            total = 0;
    int            bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        entry_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        check("valid", 64'(o_valid), 64'(mq.size() > 0));
        check("data", 64'(o_data), 64'(h.data));
        check("ctrl", 64'(o_ctrl), 64'(h.ctrl));
        check("halt", 64'(o_halt), 64'(h.halt));
        check("occupancy", 64'(o_occupancy), 64'(mq.size()));
        check("halted", 64'(o_halted), 64'(m_halted));
        check("count", 64'(o_count), 64'(m_count));
    endtask

    task automatic model_clear();
        mq.delete();
        m_halted = 1'b0;
        m_count  = '0;
    endtask

    // Drive one cycle of inputs, advance the model by the handshake rules, then check after the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic h, input logic rdy, input logic st, input logic fl);
        logic   m_ready, in_x, out_x;
        entry_t e;
        i_valid = v; i_data = d; i_ctrl = c; i_halt = h;
        i_ready = rdy; i_step = st; i_flush = fl;
        #1;
        m_ready = st && !m_halted && (mq.size() < 2);
        check("ready", 64'(o_ready), 64'(m_ready));
        in_x  = v && m_ready;
        out_x = (mq.size() > 0) && rdy && st && !m_halted;
        @(posedge i_clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (out_x) begin
                e = mq.pop_front();
                m_count = m_count + 1'b1;
                if (e.halt) m_halted = 1'b1;
            end
            if (in_x) mq.push_back('{halt: h, ctrl: c, data: d});
        end
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        #1;
        model_clear();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_occ", 64'(o_occupancy), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_halted", 64'(o_halted), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
    endtask

    logic [NW-1:0] saved;

    initial begin
        i_reset = 1'b1; i_step = 1'b1; i_flush = 1'b0; i_valid = 1'b0;
        i_data = '0; i_ctrl = '0; i_halt = 1'b0; i_ready = 1'b0;
        model_clear();
        @(negedge i_clk);
        do_reset();

        // back-to-back stream keeps one entry resident
        cyc(1, 32'h11, 16'h1, 0, 1, 1, 0);
        check("b2b_d0", 64'(o_data), 64'h11);
        cyc(1, 32'h22, 16'h2, 0, 1, 1, 0);
        check("b2b_d1", 64'(o_data), 64'h22);
        check("b2b_occ", 64'(o_occupancy), 64'd1);
        cyc(1, 32'h33, 16'h3, 0, 1, 1, 0);
        check("b2b_d2", 64'(o_data), 64'h33);
        cyc(0, 0, 0, 0, 1, 1, 0);
        check("b2b_count", 64'(o_count), 64'd3);

        // skid fill and drain
        cyc(1, 32'hA, 16'h5, 0, 0, 1, 0);
        cyc(1, 32'hB, 16'h6, 0, 0, 1, 0);
        check("skid_occ", 64'(o_occupancy), 64'd2);
        check("skid_ready", 64'(o_ready), 64'd0);
        check("skid_head", 64'(o_data), 64'hA);
        cyc(0, 0, 0, 0, 1, 1, 0);
        check("skid_next", 64'(o_data), 64'hB);
        check("skid_ready_back", 64'(o_ready), 64'd1);
        cyc(0, 0, 0, 0, 1, 1, 0);

        // flush with full stage drops same-cycle input
        cyc(1, 32'h1A, 16'h7, 0, 0, 1, 0);
        cyc(1, 32'h1B, 16'h8, 0, 0, 1, 0);
        saved = o_count;
        cyc(1, 32'hC, 16'h9, 0, 1, 1, 1);
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_ctrl", 64'(o_ctrl), 64'd0);
        check("flush_count", 64'(o_count), 64'(saved));
        cyc(0, 0, 0, 0, 1, 1, 0);
        check("flush_noC", 64'(o_valid), 64'd0);

        // step=0 freezes everything
        cyc(1, 32'h44, 16'h4, 0, 0, 1, 0);
        saved = o_count;
        for (int k = 0; k < 5; k++) cyc(1, 32'h55 + k, 16'h1, 0, 1, 0, 0);
        check("step_count", 64'(o_count), 64'(saved));
        check("step_head", 64'(o_data), 64'h44);
        check("step_ready", 64'(o_ready), 64'd0);
        cyc(0, 0, 0, 0, 1, 1, 0);

        // halt entry freezes the stage until reset
        cyc(1, 32'h1, 16'h3, 1, 0, 1, 0);
        cyc(1, 32'h2, 16'h4, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 0);
        check("halt_flag", 64'(o_halted), 64'd1);
        check("halt_head", 64'(o_data), 64'h2);
        saved = o_count;
        for (int k = 0; k < 3; k++) cyc(1, 32'h77, 16'h1, 0, 1, 1, 0);
        check("halt_ready", 64'(o_ready), 64'd0);
        check("halt_count", 64'(o_count), 64'(saved));
        check("halt_hold", 64'(o_data), 64'h2);
        do_reset();

        // counter wrap after 17 transfers
        for (int k = 0; k < 18; k++) cyc(k < 17, 32'(k + 1), 16'(k), 0, 1, 1, 0);
        check("wrap_count", 64'(o_count), 64'd1);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            if (m_halted && ($urandom_range(0, 7) == 0)) begin
                @(negedge i_clk);
                do_reset();
            end else begin
                cyc($urandom_range(0, 2) != 0, $urandom, 16'($urandom),
                    $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 9) != 0, $urandom_range(0, 30) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data payload per entry.
REQ-002 Parameter CTRL_WIDTH, default 16, SHALL set the width of the control payload per entry (EX/MEM/WB control bits).
REQ-003 Parameter CNT_WIDTH, default 32, SHALL set the width of the transfer counter.
REQ-004 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 i_clk  in  1  SHALL be the single clock, rising-edge active.
REQ-006 i_reset  in  1  SHALL be the asynchronous active-low reset (0 = reset asserted).
REQ-007 i_step  in  1  SHALL be the debug step enable; 0 freezes all transfers.
REQ-008 i_flush  in  1  SHALL be the synchronous flush: all entries become bubbles.
REQ-009 i_valid  in  1  SHALL mark upstream data as valid.
REQ-010 o_ready  out  1  SHALL indicate the stage can accept an entry this cycle.
REQ-011 i_data  in  DATA_WIDTH  SHALL be the upstream data payload.
REQ-012 i_ctrl  in  CTRL_WIDTH  SHALL be the upstream control payload.
REQ-013 i_halt  in  1  SHALL be the upstream halt-instruction marker, stored with the entry.
REQ-014 o_valid  out  1  SHALL mark the head entry as valid.
REQ-015 i_ready  in  1  SHALL indicate that downstream accepts the head entry.
REQ-016 o_data  out  DATA_WIDTH  SHALL be the head data, and SHALL be 0 when o_valid=0.
REQ-017 o_ctrl  out  CTRL_WIDTH  SHALL be the head control, and SHALL be 0 when o_valid=0 (bubble).
REQ-018 o_halt  out  1  SHALL be the head halt marker, gated by o_valid.
REQ-019 o_halted  out  1  SHALL be a sticky flag: a halt entry has left the stage.
REQ-020 o_count  out  CNT_WIDTH  SHALL count output transfers.
REQ-021 o_occupancy  out  2  SHALL report the number of stored entries (0..2).

Function
REQ-022 Storage SHALL consist of a main entry (head) and a skid entry, each holding {halt, ctrl, data}.
REQ-023 Occupancy states SHALL be EMPTY (0), ONE (main valid) and TWO (main and skid valid).
REQ-024 o_ready SHALL equal i_step & ~o_halted & (state != TWO).
REQ-025 o_valid SHALL equal (state != EMPTY).
REQ-026 An input transfer SHALL occur on a rising edge with i_valid & o_ready.
REQ-027 An output transfer SHALL occur on a rising edge with o_valid & i_ready & i_step & ~o_halted.
REQ-028 From EMPTY, an input transfer SHALL load main and move to ONE; otherwise the state SHALL hold.
REQ-029 From ONE, in-only SHALL load skid and move to TWO.
REQ-030 From ONE, out-only SHALL clear main and move to EMPTY.
REQ-031 From ONE, in and out together SHALL load main with the input and stay in ONE, giving 1 entry/cycle throughput.
REQ-032 From TWO, an output transfer SHALL move skid into main, clear skid and move to ONE; no input is possible in TWO.
REQ-033 Entries SHALL leave in arrival order, and none SHALL be lost or duplicated.
REQ-034 With i_step=0, the state, entries and o_count SHALL hold, except that i_flush still acts.
REQ-035 i_flush=1 SHALL have priority over all transfers: on the edge, state goes to EMPTY, both entries clear to 0, and any same-cycle input is dropped.
REQ-036 i_flush SHALL NOT change o_count or o_halted.
REQ-037 An output transfer whose entry has halt=1 SHALL set o_halted on that edge.
REQ-038 Once o_halted=1, no further transfers SHALL occur until reset; the remaining entries stay visible.
REQ-039 o_count SHALL increment by 1 per output transfer and wrap from 2^CNT_WIDTH-1 to 0.
REQ-040 o_occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-041 No output SHALL depend combinationally on i_data, i_ctrl or i_valid.

Reset
REQ-042 i_reset=0 SHALL immediately, without a clock, force state to EMPTY, both entries to 0, o_halted=0 and o_count=0.
REQ-043 While i_reset=0, o_valid, o_data, o_ctrl, o_halt and o_occupancy SHALL be 0.
REQ-044 On release, the first edge SHALL behave as normal operation; a transfer in progress when reset asserts is discarded.

Verification
REQ-045 Reset release, i_step=1, i_ready=1, three back-to-back inputs with data 0x11, 0x22, 0x33 -> outputs 0x11, 0x22, 0x33 on consecutive cycles, o_occupancy stays 1, o_count=3.
REQ-046 i_ready=0, inputs 0xA and 0xB -> o_occupancy=2 and o_ready=0; then i_ready=1 -> 0xA then 0xB out, o_ready returns to 1 after the first output transfer.
REQ-047 Occupancy 2 plus i_flush=1 with i_valid=1, data 0xC -> next cycle o_valid=0, o_ctrl=0, o_occupancy=0, o_count unchanged, 0xC never appears.
REQ-048 i_step=0 for 5 cycles with i_valid=1 and i_ready=1 -> no change to entries or o_count, and o_ready=0.
REQ-049 Entries 0x1 (halt=1) then 0x2 -> after 0x1 leaves, o_halted=1, 0x2 is held at the head, o_ready=0, o_count frozen; i_reset=0 then clears everything.
REQ-050 CNT_WIDTH=4, 17 output transfers -> o_count=1 (wrap).
